// File: rtl/sccb_arb_pkg.sv
// Shared types and constants for the SCCB command arbiter.
// Holds the FSM state encoding and the payload/frame widths.
package sccb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int PAYLOAD_W = 24;
    localparam int FRAME_W   = 32;

    localparam logic [7:0] DEV_ADDR_DEF = 8'h78;

endpackage

// File: rtl/sccb_cmd_arbiter_if.sv
// Requester/engine bundle of the SCCB command arbiter.
// master = requesters + I2C engine side, slave = arbiter side.
interface sccb_cmd_arbiter_if #(
    parameter int NUM_REQ = 3
);
    import sccb_arb_pkg::*;

    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_data;
    logic [NUM_REQ-1:0]           gnt;
    logic [NUM_REQ-1:0]           done;
    logic [NUM_REQ-1:0]           err;
    logic [FRAME_W-1:0]           i2c_data;
    logic                         start;
    logic                         tr_end;
    logic                         ack;
    logic                         busy;

    modport master (
        output req, req_data, tr_end, ack,
        input  gnt, done, err, i2c_data, start, busy
    );

    modport slave (
        input  req, req_data, tr_end, ack,
        output gnt, done, err, i2c_data, start, busy
    );

endinterface

// File: rtl/sccb_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker; last owner is kept one-hot.
// Search starts just above the last owner and wraps to bit 0.
module rr_pick
    import sccb_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] last_i,
    output logic [NUM_REQ-1:0] win_o
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic [NUM_REQ-1:0] pool;

    // Lowest set bit above last owner, else lowest set bit overall
    always_comb begin
        hi_mask = ~((last_i << 1) - ONE);
        hi_req  = req_i & hi_mask;
        pool    = (|hi_req) ? hi_req : req_i;
        win_o   = pool & (~pool + ONE);
    end

endmodule

// File: rtl/sccb_cmd_arbiter.sv
// Arbitrates register-write requests onto one SCCB/I2C engine.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog.
module sccb_cmd_arbiter
    import sccb_arb_pkg::*;
#(
    parameter int          NUM_REQ     = 3,
    parameter logic [7:0]  DEV_ADDR    = DEV_ADDR_DEF,
    parameter logic [15:0] TIMEOUT_CYC = 16'd2000
) (
    input logic               clock_i2c,
    input logic               camera_rst,
    sccb_cmd_arbiter_if.slave bus
);

    arb_state_e            state_q;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    err_q;
    logic [NUM_REQ-1:0]    last_q;
    logic [FRAME_W-1:0]    frame_q;
    logic                  start_q;
    logic                  busy_q;
    logic [NUM_REQ-1:0]    win;
    logic [PAYLOAD_W-1:0]  pick_data;
    logic                  timed_out;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .win_o  (win)
    );

    // Payload of the one-hot winner
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                pick_data = pick_data
                          | bus.req_data[PAYLOAD_W*i +: PAYLOAD_W];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic [15:0] wdog_d;

    assign wdog_d = wdog_q + 16'd1;

    // Counts WAIT cycles; cleared while launching
    always_ff @(posedge clock_i2c or posedge camera_rst) begin
        if (camera_rst) begin
            wdog_q <= '0;
        end else if (state_q == ST_LAUNCH) begin
            wdog_q <= '0;
        end else if (state_q == ST_WAIT) begin
            wdog_q <= wdog_d;
        end
    end

    assign timed_out = (state_q == ST_WAIT)
                     && (wdog_d == TIMEOUT_CYC);
`else
    assign timed_out = 1'b0;
`endif

    // Transaction FSM with registered handshake outputs
    always_ff @(posedge clock_i2c or posedge camera_rst) begin
        if (camera_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            frame_q <= '0;
            last_q  <= {1'b1, {(NUM_REQ-1){1'b0}}};
        end else begin
            done_q <= '0;
            err_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_q   <= win;
                        frame_q <= {DEV_ADDR, pick_data};
                        busy_q  <= 1'b1;
                        state_q <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    start_q <= 1'b1;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.tr_end || timed_out) begin
                        start_q <= 1'b0;
                        done_q  <= gnt_q;
                        err_q   <= gnt_q
                                 & {NUM_REQ{bus.ack | timed_out}};
                        last_q  <= gnt_q;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.i2c_data = frame_q;
    assign bus.start    = start_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Directed self-checking bench for sccb_cmd_arbiter.
// Build with ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_sccb_cmd_arbiter;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    sccb_cmd_arbiter_if #(.NUM_REQ(3)) bus ();

    sccb_cmd_arbiter #(
        .NUM_REQ     (3),
        .DEV_ADDR    (8'h78),
        .TIMEOUT_CYC (16'd50)
    ) dut (
        .clock_i2c  (clk),
        .camera_rst (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: start gaps, done/err legality, pulse counts
    int   cyc = 0;
    int   fall_cyc = -1;
    int   min_gap = 1000;
    int   bad_done = 0;
    int   done_cnt [3] = '{0, 0, 0};
    logic prev_start = 1'b0;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_start <= bus.start;
        if (!rst) begin
            if (prev_start && !bus.start) fall_cyc <= cyc;
            if (!prev_start && bus.start && fall_cyc >= 0
                && (cyc - fall_cyc) < min_gap)
                min_gap <= cyc - fall_cyc;
            if (!$onehot0(bus.done) || (bus.done & ~bus.gnt) != 0
                || (bus.err & ~bus.done) != 0)
                bad_done <= bad_done + 1;
            for (int i = 0; i < 3; i++)
                if (bus.done[i]) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One engine transaction: wait grant, end after dly WAIT cycles
    task automatic run_txn(input int dly, input logic ackv,
                           input logic clr,
                           output logic [2:0] g, output logic [2:0] d,
                           output logic [2:0] e,
                           output logic [31:0] fr);
        int n;
        n = 0;
        while (bus.gnt == 3'b000 && n < 20) begin
            tick();
            n++;
        end
        chk("gnt_seen", 32'(bus.gnt != 3'b000), 1);
        g  = bus.gnt;
        fr = bus.i2c_data;
        chk("start_lo_at_gnt", 32'(bus.start), 0);
        tick();
        chk("start_hi", 32'(bus.start), 1);
        repeat (dly) tick();
        bus.tr_end = 1'b1;
        bus.ack    = ackv;
        tick();
        d = bus.done;
        e = bus.err;
        chk("start_fall", 32'(bus.start), 0);
        bus.tr_end = 1'b0;
        bus.ack    = 1'b0;
        if (clr) bus.req = bus.req & ~d;
        tick();
        chk("idle_gnt", 32'(bus.gnt), 0);
        chk("idle_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [2:0]  g, d, e;
        logic [31:0] fr;
        int          snap;
        int          exp_own [6] = '{1, 2, 4, 1, 2, 4};

        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tr_end   = 1'b0;
        bus.ack      = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_start", 32'(bus.start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_data", bus.i2c_data, 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_after_rst", 32'(bus.busy), 0);

        // Fairness: all requesters held high
        bus.req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            run_txn(2, 1'b0, 1'b0, g, d, e, fr);
            chk("fair_gnt", 32'(g), exp_own[k]);
            chk("fair_done", 32'(d), exp_own[k]);
        end
        bus.req = 3'b000;

        // Single write from requester 0
        snap = done_cnt[0];
        bus.req_data[23:0] = 24'h300882;
        bus.req = 3'b001;
        run_txn(9, 1'b0, 1'b1, g, d, e, fr);
        chk("t1_gnt", 32'(g), 1);
        chk("t1_frame", fr, 32'h78300882);
        chk("t1_done", 32'(d), 1);
        chk("t1_err", 32'(e), 0);
        chk("t1_done_cnt", done_cnt[0] - snap, 1);

        // NACK on owner 1, then a clean grant
        bus.req_data[47:24] = 24'h350307;
        bus.req = 3'b010;
        run_txn(3, 1'b1, 1'b1, g, d, e, fr);
        chk("nack_frame", fr, 32'h78350307);
        chk("nack_done", 32'(d), 2);
        chk("nack_err", 32'(e), 2);
        bus.req = 3'b001;
        run_txn(1, 1'b0, 1'b1, g, d, e, fr);
        chk("after_nack_gnt", 32'(g), 1);
        chk("after_nack_err", 32'(e), 0);

        // tr_end outside WAIT must be ignored
        bus.tr_end = 1'b1;
        tick();
        chk("tr_idle_done", 32'(bus.done), 0);
        chk("tr_idle_busy", 32'(bus.busy), 0);
        bus.req = 3'b001;
        tick();
        chk("tr_launch_gnt", 32'(bus.gnt), 1);
        tick();
        chk("tr_launch_done", 32'(bus.done), 0);
        chk("tr_launch_start", 32'(bus.start), 1);
        bus.tr_end = 1'b0;
        tick();
        chk("tr_wait_hold", 32'(bus.start), 1);
        bus.tr_end = 1'b1;
        tick();
        chk("tr_wait_done", 32'(bus.done), 1);
        bus.tr_end = 1'b0;
        bus.req = 3'b000;
        tick();

        // Reset in WAIT aborts; next tie goes to index 0
        bus.req = 3'b010;
        tick();
        chk("rst_mid_gnt", 32'(bus.gnt), 2);
        tick();
        chk("rst_mid_start", 32'(bus.start), 1);
        repeat (2) tick();
        snap = done_cnt[1];
        rst = 1'b1;
        #1;
        chk("abort_start", 32'(bus.start), 0);
        chk("abort_gnt", 32'(bus.gnt), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        tick();
        chk("abort_done", 32'(bus.done), 0);
        rst = 1'b0;
        bus.req = 3'b111;
        tick();
        chk("post_rst_gnt", 32'(bus.gnt), 1);
        run_txn(1, 1'b0, 1'b1, g, d, e, fr);
        chk("post_rst_done", 32'(d), 1);
        chk("abort_no_done", done_cnt[1] - snap, 0);
        bus.req = 3'b000;
        tick();

        // Payload/req changes during WAIT are ignored
        bus.req_data[71:48] = 24'h123456;
        bus.req = 3'b100;
        tick();
        chk("hold_gnt", 32'(bus.gnt), 4);
        chk("hold_frame0", bus.i2c_data, 32'h78123456);
        tick();
        bus.req = 3'b000;
        bus.req_data[71:48] = 24'hABCDEF;
        repeat (3) tick();
        chk("hold_frame1", bus.i2c_data, 32'h78123456);
        bus.tr_end = 1'b1;
        tick();
        chk("hold_done", 32'(bus.done), 4);
        chk("hold_err", 32'(bus.err), 0);
        chk("hold_frame2", bus.i2c_data, 32'h78123456);
        bus.tr_end = 1'b0;
        tick();
        chk("hold_idle", 32'(bus.busy), 0);
        tick();
        chk("hold_no_regnt", 32'(bus.gnt), 0);

        // Engine never ends the transfer
        bus.req_data[23:0] = 24'h0A0B0C;
        bus.req = 3'b001;
        tick();
        chk("wd_gnt", 32'(bus.gnt), 1);
        tick();
        chk("wd_start_hi", 32'(bus.start), 1);
`ifdef ARB_TIMEOUT_EN
        repeat (49) tick();
        chk("wd_hold", 32'(bus.start), 1);
        chk("wd_no_done", 32'(bus.done), 0);
        tick();
        chk("wd_start_lo", 32'(bus.start), 0);
        chk("wd_done", 32'(bus.done), 1);
        chk("wd_err", 32'(bus.err), 1);
        bus.req = 3'b000;
        tick();
        chk("wd_idle", 32'(bus.busy), 0);
`else
        repeat (200) tick();
        chk("nowd_busy", 32'(bus.busy), 1);
        chk("nowd_start", 32'(bus.start), 1);
        bus.tr_end = 1'b1;
        tick();
        chk("nowd_done", 32'(bus.done), 1);
        chk("nowd_err", 32'(bus.err), 0);
        bus.tr_end = 1'b0;
        bus.req = 3'b000;
        tick();
        chk("nowd_idle", 32'(bus.busy), 0);
`endif

        tick();
        chk("done_rules", bad_done, 0);
        chk("gap_seen", 32'(min_gap < 1000), 1);
        chk("start_gap", 32'(min_gap >= 2), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sccb_cmd_arbiter.md
SCCB_CMD_ARBITER -- requirements
Module: sccb_cmd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of register-write requesters (2..8).
REQ-002 Parameter DEV_ADDR, default 8'h78: SCCB device write address placed in frame byte 3.
REQ-003 Parameter TIMEOUT_CYC, default 16'd2000: WAIT-state watchdog limit in clock_i2c cycles.
REQ-004 clock_i2c  in  1  single clock (20 kHz I2C-engine clock); all logic on its rising edge.
REQ-005 camera_rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester write request; held high until matching done.
REQ-007 req_data  in  NUM_REQ*24  per-requester {reg_addr[15:0], reg_val[7:0]}; slice i = bits [24*i+23:24*i].
REQ-008 gnt  out  NUM_REQ  one-hot owner of the current transaction; zero when idle.
REQ-009 done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-010 err  out  NUM_REQ  one-cycle pulse, coincident with done, on NACK or timeout.
REQ-011 i2c_data  out  32  frame to the I2C engine, {DEV_ADDR, req_data slice}.
REQ-012 start  out  1  engine start level; high from launch until tr_end is seen.
REQ-013 tr_end  in  1  engine end-of-transfer indication.
REQ-014 ack  in  1  engine acknowledge status, sampled with tr_end; 1 = slave NACK.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, LAUNCH, WAIT, RELEASE; encoding defined in package.
REQ-017 IDLE: if any req bit is high, pick the winner round-robin starting at last_owner+1 (mod NUM_REQ), set gnt, latch i2c_data, and go to LAUNCH.
REQ-018 LAUNCH: drive start=1 and go to WAIT; start rises exactly 1 cycle after gnt.
REQ-019 WAIT: on tr_end=1, drive start=0, pulse done[owner] and err[owner] (err only if ack=1), update last_owner, and go to RELEASE.
REQ-020 RELEASE: hold start=0 and gnt for exactly 1 cycle, then clear gnt and go to IDLE; minimum gap between consecutive starts is 2 cycles.
REQ-021 i2c_data is stable from LAUNCH through RELEASE; req_data changes during this window are ignored.
REQ-022 If req drops mid-transaction, the transaction completes normally; done still pulses.
REQ-023 Requests raised while busy wait; no request is lost or duplicated.
REQ-024 Fairness: with all requesters continuously asserted, owners cycle 0,1,..,NUM_REQ-1,0,...
REQ-025 After reset, last_owner = NUM_REQ-1, so index 0 wins the first tie.
REQ-026 tr_end outside WAIT is ignored.
REQ-027 Only one done bit pulses per transaction; done and err are never asserted outside WAIT->RELEASE.

Reset
REQ-028 On camera_rst=1, asynchronously force state=IDLE; gnt, done, err = 0; start=0; busy=0; i2c_data=0; last_owner=NUM_REQ-1; timeout counter=0.
REQ-029 Reset asserted mid-transaction aborts the transaction with no done/err pulse; start falls in the same cycle.

Configuration
REQ-030 With ARB_TIMEOUT_EN defined, a 16-bit counter clears on entry to WAIT and increments each WAIT cycle; when it reaches TIMEOUT_CYC without tr_end, behave as REQ-019 with err forced to 1.
REQ-031 Without ARB_TIMEOUT_EN, no counter is present and WAIT persists until tr_end or reset.

Structure
REQ-032 Package sccb_arb_pkg holds the FSM state type, the 24-bit request-payload and 32-bit frame width constants, and the DEV_ADDR default.
REQ-033 Round-robin selection is implemented in a sub-module rr_pick (inputs req and last_owner; output one-hot winner), combinational.

Verification
REQ-034 Single req[0] with data 24'h300882, tr_end after 10 cycles, ack=0 -> i2c_data=32'h78300882, start high 1 cycle after gnt[0], one done[0] pulse, err=0.
REQ-035 req=3'b111 held, engine model ends every transfer -> gnt order 0,1,2,0,1,2, and every start rising edge is at least 2 cycles after the preceding fall.
REQ-036 Owner 1 receives ack=1 at tr_end -> done[1] and err[1] pulse in the same cycle; next grant proceeds normally.
REQ-037 ARB_TIMEOUT_EN, TIMEOUT_CYC=50, tr_end never asserted -> start falls after 50 WAIT cycles with done and err pulses; without the macro, busy stays high indefinitely.
REQ-038 camera_rst pulsed during WAIT -> start, gnt, and busy drop immediately with no done pulse; the first grant after reset goes to index 0.
REQ-039 req[2] deasserted and req_data[2] changed during WAIT -> i2c_data unchanged and done[2] still pulses.
